prince_rnd_gen: RTL and testbench
=================================

// Module: prince_rnd_gen
// PURPOSE
//   Fresh-randomness source for the 2nd-order masked PRINCE S-box datapath.
//   A 32-bit Fibonacci LFSR is advanced OUT_W steps per delivered word.
//   Each word drives the 12-bit rnd bus of the input share refresher, which
//   sits directly downstream.
//   Valid/ready handshake, runtime reseeding, warm-up after every (re)seed
//   and a reseed-request flag after a programmable number of words.
// PARAMETERS
//   LFSR_W       32             LFSR state width; must be >= OUT_W
//   OUT_W        12             random bits per word (3 shares x 4 bits)
//   TAPS         32'h8020_0003  feedback mask; feedback bit = ^(state & TAPS)
//   SEED_DEFAULT 32'hACE1_2468  state after reset; replaces an all-zero seed
//   WARMUP_CYC   8              warm-up cycles, each advancing OUT_W steps
//   RESEED_INT   1024           words delivered before reseed_req rises
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   seed_valid   in   1       seed present this cycle
//   seed         in   LFSR_W  new LFSR seed
//   seed_ready   out  1       seed accepted when seed_valid && seed_ready
//   rnd_ready    in   1       consumer takes rnd this cycle
//   rnd_valid    out  1       rnd holds a fresh, never-delivered word
//   rnd          out  OUT_W   random word = state[OUT_W-1:0]
//   reseed_req   out  1       word count reached RESEED_INT; cleared by a seed load
//   warm         out  1       high while the block is in WARMUP
// BEHAVIOUR
//   Step function: step(s) = {s[LFSR_W-2:0], ^(s & TAPS)}.
//   Advance: adv(s) = step applied OUT_W times, unrolled into one cycle.
//   Reset (async, rst_n=0):
//     state=SEED_DEFAULT, fsm=WARMUP, wcnt=0, words=0;
//     rnd_valid=0, reseed_req=0, warm=1, seed_ready=1.
//   FSM WARMUP:
//     each cycle state<=adv(state) and wcnt++;
//     when wcnt==WARMUP_CYC-1, go to RUN. rnd_valid stays 0 throughout.
//   FSM RUN:
//     rnd_valid=1 (registered, asserted on the first RUN cycle);
//     rnd is stable while rnd_ready=0.
//     On rnd_valid && rnd_ready: state<=adv(state) and words++;
//     the next word is presented on the following cycle, so back-to-back
//     transfers run at 1 word/cycle with no bubble.
//   Seed load (seed_valid && seed_ready), from any state:
//     state<=(seed==0 ? SEED_DEFAULT : seed), fsm<=WARMUP, wcnt<=0,
//     words<=0, reseed_req<=0; rnd_valid drops on the next cycle.
//   Seed and handshake in the same cycle: the seed wins. The word on rnd
//     counts as consumed and is never presented again.
//   seed_ready is tied to 1; a seed is accepted in every state.
//   words saturates at RESEED_INT; reseed_req=(words==RESEED_INT), registered.
//     Generation continues while reseed_req=1; there is no stall.
//   The state register never becomes zero: zero seeds are substituted, and
//     a nonzero state cannot reach zero under the chosen polynomial.
//   No word is ever output twice. rnd changes only after a completed
//     handshake or after a seed load followed by warm-up.
//   rst_n assertion mid-warm-up or mid-run aborts immediately to reset values.
// TESTING
//   1 Reset; rnd_ready=1 -> rnd_valid=0 for 8 cycles, warm=1; cycle 9:
//     rnd_valid=1, rnd == golden adv^8(SEED_DEFAULT)[11:0].
//   2 RUN, rnd_ready=0 for 5 cycles -> rnd constant; then 3 ready cycles ->
//     3 distinct words matching adv^9, adv^10, adv^11 of the model.
//   3 seed=0 with seed_valid -> behaves identically to reset (same first word
//     as scenario 1).
//   4 seed=32'h0000_0001 together with rnd_valid&&rnd_ready -> next cycle
//     rnd_valid=0, warm=1; after 8 cycles rnd == adv^8(1)[11:0]; old word gone.
//   5 Stream 1024 words with ready=1 -> reseed_req rises after the 1024th
//     transfer; words keep flowing; a seed load clears reseed_req.
//   6 rst_n pulsed low mid-run -> outputs take reset values asynchronously;
//     replay matches scenario 1.

Source files
------------

// File: rtl/prince_rnd_gen.sv
// prince_rnd_gen
//   Fresh-randomness source for the 2nd-order masked PRINCE S-box datapath.
//   A Fibonacci LFSR is advanced OUT_W steps per delivered word. The low
//   OUT_W bits of the state feed the rnd bus of the input share refresher.
//   After every reset or seed load the block runs WARMUP_CYC warm-up cycles
//   before it presents its first word. After RESEED_INT delivered words it
//   raises reseed_req. Generation continues until a new seed arrives.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   seed_valid in   1       seed present this cycle
//   seed       in   LFSR_W  new LFSR seed (all-zero is replaced by SEED_DEFAULT)
//   seed_ready out  1       always 1; a seed is accepted in every state
//   rnd_ready  in   1       consumer takes rnd this cycle
//   rnd_valid  out  1       rnd holds a fresh, never-delivered word
//   rnd        out  OUT_W   random word = state[OUT_W-1:0]
//   reseed_req out  1       RESEED_INT words delivered since the last seed
//   warm       out  1       high while warming up
//
// LFSR_W must be >= OUT_W.

module prince_rnd_gen #(
    parameter int          LFSR_W       = 32,
    parameter int          OUT_W        = 12,
    parameter logic [31:0] TAPS         = 32'h8020_0003,
    parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468,
    parameter int          WARMUP_CYC   = 8,
    parameter int          RESEED_INT   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    output logic              seed_ready,
    input  logic              rnd_ready,
    output logic              rnd_valid,
    output logic [OUT_W-1:0]  rnd,
    output logic              reseed_req,
    output logic              warm
);

    localparam int WCNT_W = $clog2(WARMUP_CYC + 1);
    localparam int CNT_W  = $clog2(RESEED_INT + 1);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0]  WORDS_MAX = CNT_W'(RESEED_INT);
    localparam logic [LFSR_W-1:0] TAP_MASK  = LFSR_W'(TAPS);
    localparam logic [LFSR_W-1:0] SEED_DEF  = LFSR_W'(SEED_DEFAULT);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } fsm_t;

    fsm_t              fsm, fsm_nxt;
    logic [LFSR_W-1:0] state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [CNT_W-1:0]  words, words_nxt;
    logic              vld_nxt;
    logic              req_nxt;
    logic              load;
    logic              xfer;

    // OUT_W LFSR steps unrolled into a single combinational chain.
    logic [OUT_W:0][LFSR_W-1:0] chain;
    logic [LFSR_W-1:0]          adv_state;

    assign chain[0] = state;

    genvar g;
    generate
        for (g = 0; g < OUT_W; g++) begin : g_step
            assign chain[g+1] = {chain[g][LFSR_W-2:0], ^(chain[g] & TAP_MASK)};
        end
    endgenerate

    assign adv_state = chain[OUT_W];

    assign seed_ready = 1'b1;
    assign load       = seed_valid && seed_ready;
    assign xfer       = rnd_valid && rnd_ready;
    assign rnd        = state[OUT_W-1:0];
    assign warm       = (fsm == WARMUP);

    always_comb begin
        fsm_nxt   = fsm;
        state_nxt = state;
        wcnt_nxt  = wcnt;
        words_nxt = words;
        vld_nxt   = rnd_valid;
        req_nxt   = reseed_req;

        if (load) begin
            // A seed overrides a concurrent handshake. The word on rnd is
            // treated as consumed, because the state is replaced.
            state_nxt = (seed == '0) ? SEED_DEF : seed;
            fsm_nxt   = WARMUP;
            wcnt_nxt  = '0;
            words_nxt = '0;
            vld_nxt   = 1'b0;
            req_nxt   = 1'b0;
        end else begin
            case (fsm)
                WARMUP: begin
                    state_nxt = adv_state;
                    wcnt_nxt  = wcnt + 1'b1;
                    vld_nxt   = 1'b0;
                    if (wcnt == WCNT_LAST) begin
                        fsm_nxt  = RUN;
                        wcnt_nxt = '0;
                        vld_nxt  = 1'b1;
                    end
                end
                RUN: begin
                    vld_nxt = 1'b1;
                    if (xfer) begin
                        state_nxt = adv_state;
                        if (words != WORDS_MAX)
                            words_nxt = words + 1'b1;
                    end
                    // Registered from the next count, so the flag rises in
                    // the cycle right after the transfer that reaches the limit.
                    req_nxt = (words_nxt == WORDS_MAX);
                end
                default: begin
                    fsm_nxt = WARMUP;
                    vld_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= WARMUP;
            state      <= SEED_DEF;
            wcnt       <= '0;
            words      <= '0;
            rnd_valid  <= 1'b0;
            reseed_req <= 1'b0;
        end else begin
            fsm        <= fsm_nxt;
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            words      <= words_nxt;
            rnd_valid  <= vld_nxt;
            reseed_req <= req_nxt;
        end
    end

endmodule

// File: tb/tb_prince_rnd_gen.sv
// tb_prince_rnd_gen
//   Scoreboard bench for prince_rnd_gen. The stimulus process pushes each
//   expected word before it opens the handshake. The monitor pops an entry
//   and compares it on every rnd_valid && rnd_ready cycle. Expected words
//   come from a bit-serial reference of the LFSR recurrence.

module tb_prince_rnd_gen;

    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [31:0] DEF  = 32'hACE1_2468;

    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic [31:0] seed;
    logic        seed_ready;
    logic        rnd_ready;
    logic        rnd_valid;
    logic [11:0] rnd;
    logic        reseed_req;
    logic        warm;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    prince_rnd_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .rnd_ready  (rnd_ready),
        .rnd_valid  (rnd_valid),
        .rnd        (rnd),
        .reseed_req (reseed_req),
        .warm       (warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one step at a time, with a bit-serial parity over the tap positions.
    function automatic logic [31:0] step_m(input logic [31:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 32; i++)
            if (TAPS[i]) fb = fb ^ s[i];
        return {s[30:0], fb};
    endfunction

    function automatic logic [31:0] advn(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < n * 12; i++)
            r = step_m(r);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [31:0] s);
        exp_q.push_back(s[11:0]);
    endtask

    // Called at posedge+1 right after a reset release or a seed load.
    // Checks the 8 warm-up cycles and then the first presented word.
    task automatic expect_warmup(input logic [31:0] s, input string tag);
        logic [31:0] e;
        e = advn(s, 8);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({tag, " warm-up valid/warm"}, {30'd0, rnd_valid, warm}, 32'd1);
        end
        @(negedge clk);
        chk({tag, " run valid/warm"}, {30'd0, rnd_valid, warm}, 32'd2);
        chk({tag, " first word"}, {20'd0, rnd}, {20'd0, e[11:0]});
    endtask

    // Monitor: compares every completed handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rnd_valid === 1'b1 && rnd_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word: got %h with no word expected", rnd);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (rnd !== e) begin
                    errors++;
                    $display("FAIL word: got %h expected %h", rnd, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] m;

        rst_n      = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        rnd_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rnd_valid", {31'd0, rnd_valid}, 32'd0);
        chk("reset warm", {31'd0, warm}, 32'd1);
        chk("reset seed_ready", {31'd0, seed_ready}, 32'd1);
        chk("reset reseed_req", {31'd0, reseed_req}, 32'd0);
        m = DEF;
        chk("reset rnd", {20'd0, rnd}, {20'd0, m[11:0]});

        // Scenario 1: warm-up from reset, then the first word is consumed
        rst_n = 1'b1;
        push_word(advn(DEF, 8));
        expect_warmup(DEF, "s1");
        @(posedge clk);
        #1 rnd_ready = 1'b0;

        // Scenario 2: rnd holds while not ready, then three back-to-back words
        m = advn(DEF, 9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s2 stall hold", {20'd0, rnd}, {20'd0, m[11:0]});
        end
        @(posedge clk);
        #1;
        push_word(advn(DEF, 9));
        push_word(advn(DEF, 10));
        push_word(advn(DEF, 11));
        rnd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rnd_ready = 1'b0;

        // Scenario 3: a zero seed behaves exactly like reset
        seed_valid = 1'b1;
        seed       = 32'h0;
        @(posedge clk);
        #1 seed_valid = 1'b0;
        expect_warmup(DEF, "s3");

        // Scenario 4: a seed together with a handshake; the old word counts as consumed
        @(posedge clk);
        #1;
        push_word(advn(DEF, 8));
        rnd_ready  = 1'b1;
        seed_valid = 1'b1;
        seed       = 32'h0000_0001;
        @(posedge clk);
        #1;
        seed_valid = 1'b0;
        rnd_ready  = 1'b0;
        expect_warmup(32'h0000_0001, "s4");

        // Scenario 5: after 1024 words reseed_req rises; the stream keeps going
        @(posedge clk);
        #1;
        m = advn(32'h0000_0001, 8);
        for (int i = 0; i < 1027; i++) begin
            push_word(m);
            m = advn(m, 1);
        end
        rnd_ready = 1'b1;
        repeat (1023) @(posedge clk);
        @(negedge clk);
        chk("s5 req before 1024th", {31'd0, reseed_req}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("s5 req after 1024th", {31'd0, reseed_req}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rnd_ready = 1'b0;
        chk("s5 req holds", {31'd0, reseed_req}, 32'd1);
        chk("s5 still valid", {31'd0, rnd_valid}, 32'd1);
        seed_valid = 1'b1;
        seed       = 32'h1234_5678;
        @(posedge clk);
        #1 seed_valid = 1'b0;
        chk("s5 req cleared", {31'd0, reseed_req}, 32'd0);
        expect_warmup(32'h1234_5678, "s5");

        // Scenario 6: asynchronous reset mid-run, then replay of scenario 1
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("s6 async valid", {31'd0, rnd_valid}, 32'd0);
        chk("s6 async warm", {31'd0, warm}, 32'd1);
        m = DEF;
        chk("s6 async rnd", {20'd0, rnd}, {20'd0, m[11:0]});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_word(advn(DEF, 8));
        rnd_ready = 1'b1;
        expect_warmup(DEF, "s6");
        @(posedge clk);
        #1 rnd_ready = 1'b0;

        repeat (2) @(posedge clk);
        chk("scoreboard drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
